// File: rtl/cp_pkg.sv
// Shared encodings for the coprocessor dispatch endpoint: funct3 op codes,
// FSM states and instruction field positions.
package cp_pkg;

    typedef enum logic [2:0] {
        FUNCT_READ  = 3'b000,
        FUNCT_WRITE = 3'b001,
        FUNCT_SET   = 3'b010,
        FUNCT_CLEAR = 3'b011,
        FUNCT_ADD   = 3'b100
    } cp_funct_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } cp_state_e;

    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 7;
    localparam int F3_LSB  = 12;
    localparam int F3_W    = 3;
    localparam int IDX_LSB = 20;
    localparam int IDX_W   = 12;

    localparam logic [6:0] CP_OPCODE_DEFAULT = 7'b0001011;

endpackage

// File: rtl/coprocessor_responder_if.sv
// Per-slot coprocessor dispatch port: the CPU drives the request side, the
// coprocessor drives the registered response side.
interface coprocessor_responder_if #(
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32
);
    logic                  cp_enable;
    logic [INST_WIDTH-1:0] cp_inst;
    logic [DATA_WIDTH-1:0] cp_wdata;
    logic [DATA_WIDTH-1:0] cp_rdata;
    logic                  cp_ready;
    logic                  cp_exception;

    modport master (
        output cp_enable, cp_inst, cp_wdata,
        input  cp_rdata, cp_ready, cp_exception
    );

    modport slave (
        input  cp_enable, cp_inst, cp_wdata,
        output cp_rdata, cp_ready, cp_exception
    );
endinterface

// File: rtl/cp_reg_bank.sv
// System register bank: index 0 is a free-running cycle counter, the rest are
// plain registers with one commit write port and an asynchronous read port.
module cp_reg_bank #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_COUNT  = 8,
    localparam int AW        = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [DATA_WIDTH-1:0] counter_reg;
    logic [DATA_WIDTH-1:0] rd_view [REG_COUNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_reg <= '0;
        end else begin
            counter_reg <= counter_reg + 1'b1;
        end
    end

    assign rd_view[0] = counter_reg;

    // Index 0 has no storage; the decoder never lets a write reach it.
    genvar gi;
    generate
        for (gi = 1; gi < REG_COUNT; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] value_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    value_reg <= '0;
                end else if (wr_en && (wr_addr == AW'(gi))) begin
                    value_reg <= wr_data;
                end
            end

            assign rd_view[gi] = value_reg;
        end
    endgenerate

    assign rd_data = rd_view[rd_addr];

endmodule

// File: rtl/coprocessor_responder.sv
// Coprocessor-side endpoint of one dispatch slot: IDLE -> EXEC -> RESP FSM,
// instruction decode and the register-op ALU around cp_reg_bank.
module coprocessor_responder
    import cp_pkg::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter int         INST_WIDTH = 32,
    parameter int         REG_COUNT  = 8,
    parameter int         LATENCY    = 2,
    parameter logic [6:0] CP_OPCODE  = CP_OPCODE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    coprocessor_responder_if.slave  cp
);

    localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    cp_state_e             state_reg, state_next;
    logic [CW-1:0]         count_reg, count_next;
    logic [INST_WIDTH-1:0] inst_reg, inst_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic                  ready_reg, ready_next;
    logic                  exc_reg, exc_next;
    logic                  wr_en_reg, wr_en_next;
    logic [AW-1:0]         wr_addr_reg, wr_addr_next;
    logic [DATA_WIDTH-1:0] wr_data_reg, wr_data_next;

    logic [OPC_W-1:0]      opcode;
    logic [F3_W-1:0]       funct3;
    logic [IDX_W-1:0]      idx;
    cp_funct_e             funct;
    logic                  illegal;
    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] old_value;
    logic [DATA_WIDTH-1:0] new_value;
    logic                  commit;
    logic                  unused_inst_parity;

    assign opcode  = inst_reg[OPC_LSB +: OPC_W];
    assign funct3  = inst_reg[F3_LSB +: F3_W];
    assign idx     = inst_reg[IDX_LSB +: IDX_W];
    assign funct   = cp_funct_e'(funct3);
    assign rd_addr = idx[AW-1:0];
    assign unused_inst_parity = ^inst_reg;

    // The full 12-bit index is range-checked, so aliasing via rd_addr is harmless.
    assign illegal = (opcode != CP_OPCODE)
                   || (funct3 > 3'b100)
                   || ({1'b0, idx} >= 13'(REG_COUNT))
                   || ((idx == '0) && (funct != FUNCT_READ));

    always_comb begin
        new_value = old_value;
        case (funct)
            FUNCT_WRITE: new_value = wdata_reg;
            FUNCT_SET:   new_value = old_value | wdata_reg;
            FUNCT_CLEAR: new_value = old_value & ~wdata_reg;
            FUNCT_ADD:   new_value = old_value + wdata_reg;
            default:     new_value = old_value;
        endcase
    end

    cp_reg_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_reg_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (rd_addr),
        .rd_data (old_value),
        .wr_en   (commit),
        .wr_addr (wr_addr_reg),
        .wr_data (wr_data_reg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            inst_reg    <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            ready_reg   <= 1'b0;
            exc_reg     <= 1'b0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            inst_reg    <= inst_next;
            wdata_reg   <= wdata_next;
            rdata_reg   <= rdata_next;
            ready_reg   <= ready_next;
            exc_reg     <= exc_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    // Response outputs default to zero so they can only be non-zero in RESP.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        inst_next    = inst_reg;
        wdata_next   = wdata_reg;
        rdata_next   = '0;
        ready_next   = 1'b0;
        exc_next     = 1'b0;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        commit       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cp.cp_enable) begin
                    inst_next  = cp.cp_inst;
                    wdata_next = cp.cp_wdata;
                    count_next = CW'(LATENCY - 1);
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (!cp.cp_enable) begin
                    state_next = IDLE;
                end else if (count_reg == '0) begin
                    ready_next   = 1'b1;
                    exc_next     = illegal;
                    rdata_next   = illegal ? '0 : old_value;
                    wr_en_next   = !illegal && (funct != FUNCT_READ);
                    wr_addr_next = rd_addr;
                    wr_data_next = new_value;
                    state_next   = RESP;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
            RESP: begin
                // Enable still high is the handshake; low is a flush that drops the write.
                commit     = cp.cp_enable && wr_en_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cp.cp_rdata     = rdata_reg;
    assign cp.cp_ready     = ready_reg;
    assign cp.cp_exception = exc_reg;

endmodule

// File: tb/tb_coprocessor_responder.sv
// Directed bench for coprocessor_responder: register ops, illegal decodes,
// abort/flush/reset behaviour and back-to-back counter reads.
module tb_coprocessor_responder;

    localparam int DW = 64;
    localparam int IW = 32;
    localparam logic [6:0] OPC = 7'b0001011;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    coprocessor_responder_if #(.DATA_WIDTH(DW), .INST_WIDTH(IW)) cp_bus ();

    coprocessor_responder #(
        .DATA_WIDTH (DW),
        .INST_WIDTH (IW),
        .REG_COUNT  (8),
        .LATENCY    (2),
        .CP_OPCODE  (OPC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cp    (cp_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3,
                                            input logic [11:0] idx);
        return {idx, 5'd0, f3, 5'd0, opc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full transaction starting #1 after a rising edge with the DUT in IDLE.
    task automatic txn(input string tag, input logic [31:0] inst, input logic [63:0] wdata,
                       input bit hold, output logic [63:0] rdata, output logic exc);
        int cyc;
        cp_bus.cp_enable = 1'b1;
        cp_bus.cp_inst   = inst;
        cp_bus.cp_wdata  = wdata;
        cyc = 0;
        while (!cp_bus.cp_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd3);
        rdata = cp_bus.cp_rdata;
        exc   = cp_bus.cp_exception;
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 64'(cp_bus.cp_ready), 64'd0);
        if (!hold) cp_bus.cp_enable = 1'b0;
        $display("txn %s inst=%h wdata=%h rdata=%h exc=%0b cycles=%0d", tag, inst, wdata, rdata, exc, cyc);
    endtask

    logic [63:0] rd, rd2;
    logic        ex;
    logic        seen;
    int          n;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        cp_bus.cp_enable = 1'b0;
        cp_bus.cp_inst   = '0;
        cp_bus.cp_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(cp_bus.cp_ready), 64'd0);
        chk("rst_exc", 64'(cp_bus.cp_exception), 64'd0);
        chk("rst_rdata", cp_bus.cp_rdata, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read back
        txn("wr3", mk_inst(OPC, 3'b001, 12'd3), 64'hA5, 1'b0, rd, ex);
        chk("wr3_rdata", rd, 64'd0);
        chk("wr3_exc", 64'(ex), 64'd0);
        txn("rd3", mk_inst(OPC, 3'b000, 12'd3), 64'h0, 1'b0, rd, ex);
        chk("rd3_rdata", rd, 64'hA5);
        chk("rd3_exc", 64'(ex), 64'd0);

        // SET / CLEAR
        txn("wr3b", mk_inst(OPC, 3'b001, 12'd3), 64'hF0, 1'b0, rd, ex);
        chk("wr3b_rdata", rd, 64'hA5);
        txn("set3", mk_inst(OPC, 3'b010, 12'd3), 64'h0F, 1'b0, rd, ex);
        chk("set3_rdata", rd, 64'hF0);
        txn("rd3s", mk_inst(OPC, 3'b000, 12'd3), 64'h0, 1'b0, rd, ex);
        chk("rd3s_rdata", rd, 64'hFF);
        txn("clr3", mk_inst(OPC, 3'b011, 12'd3), 64'h0F, 1'b0, rd, ex);
        chk("clr3_rdata", rd, 64'hFF);
        txn("rd3c", mk_inst(OPC, 3'b000, 12'd3), 64'h0, 1'b0, rd, ex);
        chk("rd3c_rdata", rd, 64'hF0);

        // ADD wraps modulo 2^64
        txn("wr2", mk_inst(OPC, 3'b001, 12'd2), {64{1'b1}}, 1'b0, rd, ex);
        txn("add2", mk_inst(OPC, 3'b100, 12'd2), 64'd1, 1'b0, rd, ex);
        chk("add2_rdata", rd, {64{1'b1}});
        chk("add2_exc", 64'(ex), 64'd0);
        txn("rd2", mk_inst(OPC, 3'b000, 12'd2), 64'h0, 1'b0, rd, ex);
        chk("rd2_rdata", rd, 64'd0);

        // Illegal instructions
        txn("bad_opc", mk_inst(7'h33, 3'b001, 12'd3), 64'h11, 1'b0, rd, ex);
        chk("bad_opc_exc", 64'(ex), 64'd1);
        chk("bad_opc_rdata", rd, 64'd0);
        txn("bad_f3", mk_inst(OPC, 3'b111, 12'd3), 64'h22, 1'b0, rd, ex);
        chk("bad_f3_exc", 64'(ex), 64'd1);
        chk("bad_f3_rdata", rd, 64'd0);
        txn("bad_idx", mk_inst(OPC, 3'b000, 12'd8), 64'h0, 1'b0, rd, ex);
        chk("bad_idx_exc", 64'(ex), 64'd1);
        chk("bad_idx_rdata", rd, 64'd0);
        txn("wr0", mk_inst(OPC, 3'b001, 12'd0), 64'h33, 1'b0, rd, ex);
        chk("wr0_exc", 64'(ex), 64'd1);
        chk("wr0_rdata", rd, 64'd0);
        txn("rd3i", mk_inst(OPC, 3'b000, 12'd3), 64'h0, 1'b0, rd, ex);
        chk("rd3i_rdata", rd, 64'hF0);
        chk("rd3i_exc", 64'(ex), 64'd0);

        // Abort mid-EXEC
        cp_bus.cp_enable = 1'b1;
        cp_bus.cp_inst   = mk_inst(OPC, 3'b001, 12'd3);
        cp_bus.cp_wdata  = 64'h123;
        @(posedge clk); #1;
        cp_bus.cp_enable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | cp_bus.cp_ready;
        end
        chk("abort_no_ready", 64'(seen), 64'd0);
        txn("rd3a", mk_inst(OPC, 3'b000, 12'd3), 64'h0, 1'b0, rd, ex);
        chk("rd3a_rdata", rd, 64'hF0);

        // Flush in RESP
        cp_bus.cp_enable = 1'b1;
        cp_bus.cp_inst   = mk_inst(OPC, 3'b001, 12'd3);
        cp_bus.cp_wdata  = 64'h456;
        n = 0;
        while (!cp_bus.cp_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("flush_ready", 64'(cp_bus.cp_ready), 64'd1);
        cp_bus.cp_enable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen = seen | cp_bus.cp_ready;
        end
        chk("flush_no_ready", 64'(seen), 64'd0);
        txn("rd3f", mk_inst(OPC, 3'b000, 12'd3), 64'h0, 1'b0, rd, ex);
        chk("rd3f_rdata", rd, 64'hF0);

        // Reset while in RESP clears outputs immediately and wipes registers
        cp_bus.cp_enable = 1'b1;
        cp_bus.cp_inst   = mk_inst(OPC, 3'b000, 12'd3);
        n = 0;
        while (!cp_bus.cp_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rstresp_rdata_pre", cp_bus.cp_rdata, 64'hF0);
        rst_n = 1'b0;
        #1;
        chk("rstresp_ready", 64'(cp_bus.cp_ready), 64'd0);
        chk("rstresp_rdata", cp_bus.cp_rdata, 64'd0);
        cp_bus.cp_enable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn("rd3r", mk_inst(OPC, 3'b000, 12'd3), 64'h0, 1'b0, rd, ex);
        chk("rd3r_rdata", rd, 64'd0);

        // Reset mid-EXEC discards the pending write
        cp_bus.cp_enable = 1'b1;
        cp_bus.cp_inst   = mk_inst(OPC, 3'b001, 12'd3);
        cp_bus.cp_wdata  = 64'h77;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstexec_ready", 64'(cp_bus.cp_ready), 64'd0);
        chk("rstexec_exc", 64'(cp_bus.cp_exception), 64'd0);
        chk("rstexec_rdata", cp_bus.cp_rdata, 64'd0);
        cp_bus.cp_enable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn("rd3e", mk_inst(OPC, 3'b000, 12'd3), 64'h0, 1'b0, rd, ex);
        chk("rd3e_rdata", rd, 64'd0);

        // Back-to-back counter reads with enable held
        txn("cnt_a", mk_inst(OPC, 3'b000, 12'd0), 64'h0, 1'b1, rd, ex);
        chk("cnt_a_exc", 64'(ex), 64'd0);
        txn("cnt_b", mk_inst(OPC, 3'b000, 12'd0), 64'h0, 1'b0, rd2, ex);
        chk("cnt_delta", rd2 - rd, 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
